// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10-bit
// frame clocked by the device, ACK sampling and line-idle wait, with timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t           state_r;
  logic [1:0]       clk_sync_r;
  logic [1:0]       dat_sync_r;
  logic             clk_prev_r;
  logic [9:0]       frame_r;
  logic [3:0]       bit_cnt_r;
  logic [INH_W-1:0] inh_cnt_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic             nack_r;

  logic fall_s;
  logic line_idle_s;
  logic timed_s;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  assign fall_s      = clk_prev_r & ~clk_sync_r[1];
  assign line_idle_s = clk_sync_r[1] & dat_sync_r[1];
  assign timed_s     = ((state_r == SEND) || (state_r == ACK) || (state_r == WAIT_IDLE)) &&
                       (to_cnt_r == TO_LAST);

  // Two-flop synchronizers on the raw lines plus the previous synced clock for edge detection.
  always_ff @(posedge Clk) begin
    if (reset) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
      clk_prev_r <= 1'b1;
    end else begin
      clk_sync_r <= {clk_sync_r[0], ps2_clk_in};
      dat_sync_r <= {dat_sync_r[0], ps2_dat_in};
      clk_prev_r <= clk_sync_r[1];
    end
  end

  // Transfer FSM with registered line enables, handshake and result pulses.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      frame_r    <= 10'd0;
      bit_cnt_r  <= 4'd0;
      inh_cnt_r  <= '0;
      to_cnt_r   <= '0;
      nack_r     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      // Timeout wins over any falling edge seen in the same cycle.
      if (timed_s) begin
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        error      <= 1'b1;
        tx_ready   <= 1'b1;
        busy       <= 1'b0;
        state_r    <= IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            if (tx_valid && tx_ready) begin
              frame_r    <= {1'b1, odd_parity(tx_data), tx_data};
              inh_cnt_r  <= '0;
              to_cnt_r   <= '0;
              bit_cnt_r  <= 4'd0;
              nack_r     <= 1'b0;
              ps2_clk_oe <= 1'b1;
              tx_ready   <= 1'b0;
              busy       <= 1'b1;
              state_r    <= INHIBIT;
            end else begin
              tx_ready <= 1'b1;
              busy     <= 1'b0;
            end
          end
          INHIBIT: begin
            if (inh_cnt_r == INH_LAST) begin
              ps2_dat_oe <= 1'b1;
              state_r    <= REQ;
            end else begin
              inh_cnt_r <= inh_cnt_r + INH_W'(1);
            end
          end
          REQ: begin
            ps2_clk_oe <= 1'b0;
            bit_cnt_r  <= 4'd0;
            to_cnt_r   <= '0;
            state_r    <= SEND;
          end
          SEND: begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
            if (fall_s) begin
              ps2_dat_oe <= ~frame_r[0];
              frame_r    <= {1'b0, frame_r[9:1]};
              bit_cnt_r  <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd9) begin
                state_r <= ACK;
              end else begin
                state_r <= SEND;
              end
            end else begin
              state_r <= SEND;
            end
          end
          ACK: begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
            if (fall_s) begin
              nack_r  <= dat_sync_r[1];
              state_r <= WAIT_IDLE;
            end else begin
              state_r <= ACK;
            end
          end
          WAIT_IDLE: begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
            if (line_idle_s) begin
              done     <= ~nack_r;
              error    <= nack_r;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              state_r  <= IDLE;
            end else begin
              state_r <= WAIT_IDLE;
            end
          end
          default: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device model clocks frames out of
// the host; a scoreboard monitor checks every done/error pulse against expectations.
module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int TO  = 2000;
  localparam int H   = 20;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, done, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
    .busy(busy), .done(done), .error(error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          is_err;
    bit          chk_frame;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] obs_frame;
  int          n_checks = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame as the device sees it on the wire: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Scoreboard monitor: every result pulse must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (done || error) begin
        check("done_and_error_exclusive", {31'd0, done & error}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, done, error}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_kind", {31'd0, error}, {31'd0, e.is_err});
          check("result_not_other", {31'd0, done}, {31'd0, ~e.is_err});
          if (e.chk_frame) check("wire_frame", {21'd0, obs_frame}, {21'd0, e.frame});
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!tx_ready && n < TO + 100) begin
      @(negedge Clk);
      n++;
    end
    check(name, {31'd0, tx_ready}, 32'd1);
  endtask

  // mode: 0 ACK, 1 NACK, 2 tx_valid poked mid-frame, 3 silent device, 4 reset after 4th fall
  task automatic do_xfer(input logic [7:0] d, input int mode);
    exp_t e;
    int   n_inh, n_req, lat;
    e.is_err    = (mode == 1 || mode == 3);
    e.chk_frame = (mode != 3);
    e.frame     = model_frame(d);
    if (mode != 4) exp_q.push_back(e);
    @(negedge Clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge Clk);
    tx_valid = 1'b0;
    check("busy_after_accept", {30'd0, busy, tx_ready}, 32'd2);
    n_inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && n_inh < INH + 10) begin
      n_inh++;
      @(negedge Clk);
    end
    n_req = 0;
    while (ps2_clk_oe && ps2_dat_oe && n_req < 5) begin
      n_req++;
      @(negedge Clk);
    end
    check("inhibit_len", n_inh, INH);
    check("req_len", n_req, 1);
    check("clk_released_start_held", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd1);
    if (mode == 3) begin
      lat = 0;
      while (!error && lat < TO + 10) begin
        @(negedge Clk);
        lat++;
      end
      check("timeout_latency", lat, TO);
      check("timeout_lines_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
      return;
    end
    obs_frame = 11'd0;
    repeat (H) @(negedge Clk);
    for (int k = 0; k < 11; k++) begin
      obs_frame[k] = ps2_dat_in;
      if (k == 10) dev_dat_low = (mode != 1);
      if (k == 5 && mode == 2) begin
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        @(negedge Clk);
        check("ignored_while_busy", {31'd0, tx_ready}, 32'd0);
        tx_valid = 1'b0;
      end
      dev_clk_low = 1'b1;
      if (mode == 4 && k == 3) begin
        repeat (5) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        check("abort_state", {27'd0, ps2_clk_oe, ps2_dat_oe, tx_ready, done, error}, 32'h4);
        dev_clk_low = 1'b0;
        return;
      end
      repeat (H) @(negedge Clk);
      check("host_clk_released", {31'd0, ps2_clk_oe}, 32'd0);
      dev_clk_low = 1'b0;
      repeat (H) @(negedge Clk);
    end
    dev_dat_low = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    repeat (3) @(negedge Clk);
    reset = 1'b0;
    check("reset_state", {26'd0, ps2_clk_oe, ps2_dat_oe, tx_ready, busy, done, error}, 32'h8);

    do_xfer(8'hED, 0); wait_ready("ready_ED");
    do_xfer(8'h00, 0); wait_ready("ready_00");
    do_xfer(8'hFF, 0); wait_ready("ready_FF");
    do_xfer(8'hA3, 1); wait_ready("ready_nack");
    do_xfer(8'h5A, 2); wait_ready("ready_poke");
    do_xfer(8'h3C, 3); wait_ready("ready_timeout");
    do_xfer(8'h81, 4);
    repeat (10) @(negedge Clk);
    check("abort_no_pending", exp_q.size(), 0);
    do_xfer(8'hF4, 0); wait_ready("ready_F4");
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom_range(0, 255));
      do_xfer(rd, ($urandom_range(0, 3) == 0) ? 1 : 0);
      wait_ready("ready_random");
    end
    repeat (20) @(negedge Clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
